// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory port arbiter: state encoding,
// parameter defaults, requester IDs and a counter-width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam int STARVE_MAX_DEF  = 4;
  localparam int TIMEOUT_CYC_DEF = 255;

  localparam logic [1:0] GRANT_NONE = 2'd0;
  localparam logic [1:0] GRANT_I    = 2'd1;
  localparam logic [1:0] GRANT_D    = 2'd2;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Priority decision: data wins unless a waiting fetch has already watched
// STARVE_MAX consecutive data grants go by.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int SW         = cnt_width(STARVE_MAX)
) (
  input  logic          i_req,
  input  logic          d_req,
  input  logic [SW-1:0] streak,
  output logic [1:0]    grant
);

  logic starved;

  assign starved = i_req && (streak == SW'(STARVE_MAX));

  always_comb begin
    grant = GRANT_NONE;
    if (d_req && !starved) begin
      grant = GRANT_D;
    end else if (i_req) begin
      grant = GRANT_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between an instruction-fetch and a data requester,
// with anti-starvation for fetches and a per-transaction ack timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX  = STARVE_MAX_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteen,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        bus_err,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester raises x_req with stable x_* fields; the request is
  // taken on the first edge it is chosen and may then be dropped. x_ack pulses
  // once per taken request. On the memory side mem_req stays high until a cycle
  // with mem_ack (which may be combinational), or until the timeout fires.
  localparam int SW = cnt_width(STARVE_MAX);
  localparam int WW = cnt_width(TIMEOUT_CYC - 1);

  arb_state_e    state_q, state_d;
  logic [1:0]    grant;
  logic [SW-1:0] streak_q;
  logic [WW-1:0] wait_q;
  logic          owner_d_q;
  logic          timeout_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          we_q;
  logic [3:0]    byteen_q;
  logic          wait_expired;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .SW         (SW)
  ) u_pick (
    .i_req  (i_req),
    .d_req  (d_req),
    .streak (streak_q),
    .grant  (grant)
  );

  assign wait_expired = (wait_q == WW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant == GRANT_D) begin
          state_d = ST_GNT_D;
        end else if (grant == GRANT_I) begin
          state_d = ST_GNT_I;
        end
      end
      ST_GNT_I, ST_GNT_D: begin
        if (mem_ack || wait_expired) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_q  <= '0;
      wait_q    <= '0;
      owner_d_q <= 1'b0;
      timeout_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      byteen_q  <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant != GRANT_NONE) begin
            owner_d_q <= (grant == GRANT_D);
            timeout_q <= 1'b0;
            wait_q    <= '0;
            if (grant == GRANT_D) begin
              addr_q   <= d_addr;
              wdata_q  <= d_wdata;
              we_q     <= d_we;
              byteen_q <= d_byteen;
              // Streak only grows while a fetch is actually being held off.
              if (!i_req) begin
                streak_q <= '0;
              end else if (streak_q != SW'(STARVE_MAX)) begin
                streak_q <= streak_q + SW'(1);
              end
            end else begin
              addr_q   <= i_addr;
              wdata_q  <= '0;
              we_q     <= 1'b0;
              byteen_q <= '0;
              streak_q <= '0;
            end
          end
        end
        ST_GNT_I, ST_GNT_D: begin
          if (mem_ack) begin
            if (state_q == ST_GNT_D) begin
              d_rdata <= mem_rdata;
            end else begin
              i_rdata <= mem_rdata;
            end
          end else if (wait_expired) begin
            timeout_q <= 1'b1;
            if (state_q == ST_GNT_D) begin
              d_rdata <= '0;
            end else begin
              i_rdata <= '0;
            end
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // mem_req decodes straight from the async-reset state, so reset drops it at once.
  assign mem_req    = (state_q == ST_GNT_I) || (state_q == ST_GNT_D);
  assign mem_we     = (state_q == ST_GNT_D) && we_q;
  assign mem_byteen = (state_q == ST_GNT_D) ? byteen_q : 4'b0000;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

  assign i_ack      = (state_q == ST_RESP) && !owner_d_q;
  assign d_ack      = (state_q == ST_RESP) && owner_d_q;
  assign bus_err    = (state_q == ST_RESP) && timeout_q;
  assign busy       = (state_q != ST_IDLE) || i_req || d_req;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: memory responder model with
// programmable latency, grant-order scoreboard and hand-computed checks.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byteen;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy;
  logic        bus_err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic        sb_en;
  logic        prev_req;

  logic [7:0]  mem_cnt;
  logic [7:0]  mem_lat;
  logic        mem_hang;

  mem_port_arbiter #(
    .STARVE_MAX  (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_ack      (i_ack),
    .i_rdata    (i_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_byteen   (d_byteen),
    .d_ack      (d_ack),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_byteen (mem_byteen),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .bus_err    (bus_err),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: acks after mem_lat waiting cycles, data = 0xA5000000 | addr
  always @(posedge clk or posedge reset) begin
    if (reset) mem_cnt <= 8'd0;
    else if (mem_req && !mem_ack) mem_cnt <= mem_cnt + 8'd1;
    else mem_cnt <= 8'd0;
  end
  assign mem_ack   = mem_req && !mem_hang && (mem_cnt >= mem_lat);
  assign mem_rdata = 32'hA500_0000 | mem_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (busy && k < bound) begin
      step();
      k++;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  // scoreboard: address of each new grant against the expected order
  always @(negedge clk) begin
    if (sb_en && mem_req && !prev_req && exp_q.size() > 0)
      check("grant_order", mem_addr, exp_q.pop_front());
    prev_req = mem_req;
  end

  initial begin
    int n_req;
    int n_ack;
    int k;
    reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_byteen = '0; mem_lat = 8'd0; mem_hang = 1'b0;
    sb_en = 1'b0; prev_req = 1'b0;
    repeat (2) step();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_byteen", {28'd0, mem_byteen}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    step();

    // single fetch, same-cycle ack
    i_req = 1'b1; i_addr = 32'h0000_3000;
    step();
    check("f_mem_req", {31'd0, mem_req}, 32'd1);
    check("f_mem_addr", mem_addr, 32'h0000_3000);
    check("f_mem_we", {31'd0, mem_we}, 32'd0);
    check("f_i_ack_early", {31'd0, i_ack}, 32'd0);
    i_req = 1'b0;
    step();
    check("f_i_ack", {31'd0, i_ack}, 32'd1);
    check("f_mem_req_resp", {31'd0, mem_req}, 32'd0);
    check("f_i_rdata", i_rdata, 32'hA500_3000);
    check("f_bus_err", {31'd0, bus_err}, 32'd0);
    step();
    check("f_i_ack_once", {31'd0, i_ack}, 32'd0);
    check("f_busy_idle", {31'd0, busy}, 32'd0);

    // fetch dropped one cycle after grant, latency 2
    i_req = 1'b1; i_addr = 32'h0000_4000; mem_lat = 8'd2;
    step();
    n_req = 0; n_ack = 0;
    for (int j = 0; j < 8; j++) begin
      if (j == 1) i_req = 1'b0;
      if (mem_req) n_req++;
      if (i_ack) n_ack++;
      step();
    end
    check("drop_req_cycles", n_req, 32'd3);
    check("drop_ack_count", n_ack, 32'd1);
    check("drop_i_rdata", i_rdata, 32'hA500_4000);
    mem_lat = 8'd0;

    // simultaneous store and fetch: data first
    i_req = 1'b1; i_addr = 32'h0000_5000;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0010; d_wdata = 32'hDEAD_BEEF; d_byteen = 4'b0011;
    step();
    check("both_mem_addr", mem_addr, 32'h0000_0010);
    check("both_mem_we", {31'd0, mem_we}, 32'd1);
    check("both_mem_byteen", {28'd0, mem_byteen}, 32'h3);
    check("both_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    d_req = 1'b0; d_we = 1'b0;
    step();
    check("both_d_ack", {30'd0, i_ack, d_ack}, 32'h1);
    check("both_resp_no_req", {31'd0, mem_req}, 32'd0);
    step();
    check("both_idle_busy", {31'd0, mem_req, busy}, 32'h1);
    step();
    check("both_i_mem_addr", mem_addr, 32'h0000_5000);
    check("both_i_we_be", {27'd0, mem_we, mem_byteen}, 32'd0);
    i_req = 1'b0;
    step();
    check("both_i_ack", {30'd0, i_ack, d_ack}, 32'h2);
    check("both_i_rdata", i_rdata, 32'hA500_5000);
    step();

    // starvation: D,D,D,D,I,D
    exp_q.push_back(32'h20); exp_q.push_back(32'h20); exp_q.push_back(32'h20);
    exp_q.push_back(32'h20); exp_q.push_back(32'h6000); exp_q.push_back(32'h20);
    sb_en = 1'b1;
    i_req = 1'b1; i_addr = 32'h0000_6000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0020; d_byteen = 4'b1111;
    k = 0;
    while (exp_q.size() > 0 && k < 40) begin
      step();
      k++;
    end
    i_req = 1'b0; d_req = 1'b0;
    sb_en = 1'b0;
    check("starve_drain", exp_q.size(), 32'd0);
    exp_q.delete();
    wait_idle(10);
    step();

    // timeout with mem_ack stuck low
    mem_hang = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040;
    step();
    d_req = 1'b0;
    check("hold_d_rdata", d_rdata, 32'hA500_0020);
    check("hold_i_rdata", i_rdata, 32'hA500_6000);
    n_req = 0; k = 0;
    while (!d_ack && k < 20) begin
      if (mem_req) n_req++;
      step();
      k++;
    end
    check("to_gnt_cycles", n_req, 32'd8);
    check("to_d_ack", {31'd0, d_ack}, 32'd1);
    check("to_bus_err", {31'd0, bus_err}, 32'd1);
    check("to_d_rdata", d_rdata, 32'd0);
    step();
    check("to_bus_err_pulse", {30'd0, bus_err, d_ack}, 32'd0);
    mem_hang = 1'b0;

    // reset in the middle of a 3-cycle data access
    mem_lat = 8'd3;
    d_req = 1'b1; d_addr = 32'h0000_0080;
    step();
    d_req = 1'b0;
    step();
    check("mid_pre_req", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_req_drop", {31'd0, mem_req}, 32'd0);
    step();
    reset = 1'b0;
    n_ack = 0;
    for (int j = 0; j < 6; j++) begin
      step();
      if (d_ack || i_ack) n_ack++;
    end
    check("mid_no_ack", n_ack, 32'd0);
    check("mid_d_rdata_rst", d_rdata, 32'd0);
    mem_lat = 8'd1;
    d_req = 1'b1; d_addr = 32'h0000_0084;
    step();
    d_req = 1'b0;
    step();
    step();
    check("mid_new_ack", {31'd0, d_ack}, 32'd1);
    check("mid_new_rdata", d_rdata, 32'hA500_0084);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive data grants allowed while a fetch request waits.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255: cycles without mem_ack before a transaction is aborted.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-005 SHALL have ports i_req in 1, i_addr in 32: instruction-fetch request and word address.
REQ-006 SHALL have ports i_ack out 1, i_rdata out 32: fetch completion pulse and fetched word.
REQ-007 SHALL have ports d_req in 1, d_we in 1, d_addr in 32, d_wdata in 32, d_byteen in 4: data load/store request.
REQ-008 SHALL have ports d_ack out 1, d_rdata out 32: data completion pulse and load word.
REQ-009 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_byteen out 4: shared memory request.
REQ-010 SHALL have ports mem_rdata in 32, mem_ack in 1: shared memory response; mem_ack may be combinational from mem_req.
REQ-011 SHALL have ports busy out 1 (pipeline stall source) and bus_err out 1 (timeout pulse).

Function
REQ-012 SHALL implement FSM states IDLE, GNT_I, GNT_D, RESP.
REQ-013 In IDLE with d_req=1, SHALL go to GNT_D, unless i_req=1 and streak==STARVE_MAX, in which case it goes to GNT_I.
REQ-014 In IDLE with only i_req=1, SHALL go to GNT_I; with no request, SHALL stay in IDLE.
REQ-015 SHALL latch the granted requester's address, write data, we and byteen on the IDLE->GNT edge and drive mem_* only from these latches.
REQ-016 SHALL assert mem_req=1 in GNT_I/GNT_D only; mem_we and mem_byteen SHALL be forced to 0 in GNT_I.
REQ-017 In GNT_x with mem_ack=1, SHALL register mem_rdata into x_rdata and go to RESP.
REQ-018 In RESP, SHALL pulse x_ack=1 for exactly one cycle for the granted requester, ignore all requests, and then go to IDLE.
REQ-019 Minimum latency SHALL be: request sampled at edge t, mem_req high in cycle t+1, x_ack high in cycle t+2 (ack returned in the same cycle).
REQ-020 streak SHALL increment on each D grant while i_req=1, clear on every I grant or on a D grant with i_req=0, and saturate at STARVE_MAX.
REQ-021 A wait counter SHALL count GNT cycles without mem_ack; at TIMEOUT_CYC-1 the arbiter SHALL go to RESP with bus_err=1 and x_rdata=0, x_ack still pulsing.
REQ-022 A requester dropping x_req mid-transaction SHALL NOT abort the transaction; the ack SHALL still pulse.
REQ-023 busy SHALL be 1 whenever state != IDLE, or when state == IDLE and either req is high.
REQ-024 x_rdata SHALL hold its value until the next completion for that requester.

Reset
REQ-025 On reset: state=IDLE, mem_req=0, mem_we=0, mem_byteen=0, mem_addr=0, mem_wdata=0, i_ack=d_ack=0, i_rdata=d_rdata=0, bus_err=0, streak=0, wait counter=0.
REQ-026 Reset asserted mid-transaction SHALL drop mem_req immediately (asynchronously) and SHALL produce no ack after release.

Structure
REQ-027 The state encoding, the STARVE_MAX/TIMEOUT_CYC defaults and the requester-ID constants SHALL live in a shared package, mem_arb_pkg.
REQ-028 The priority/starvation decision SHALL be one combinational sub-module, mem_arb_pick (inputs i_req, d_req, streak; output grant ID).

Verification
REQ-029 Single fetch i_addr=0x3000 with mem_ack returned in the same cycle as mem_req -> mem_req high 1 cycle, mem_addr=0x3000, mem_we=0, i_ack pulse 2 cycles after request, i_rdata=mem_rdata.
REQ-030 Simultaneous i_req and d_req (store, d_addr=0x10, byteen=4'b0011) -> data is served first with mem_we=1 and mem_byteen=0011, then the fetch is served.
REQ-031 d_req held constantly high and i_req high, STARVE_MAX=4 -> grant order D,D,D,D,I,D...
REQ-032 mem_ack held at 0, TIMEOUT_CYC=8 -> after 8 GNT cycles, bus_err and d_ack pulse together with d_rdata=0.
REQ-033 Reset asserted while in GNT_D with 3-cycle memory latency -> mem_req drops at once; no d_ack after release; a new request completes normally.
REQ-034 i_req dropped one cycle after grant -> the transaction completes and i_ack still pulses once; there is no second grant while in RESP.
